// File: rtl/data_mem_burst_pkg.sv
// Shared types and sizing helpers for the burst data memory.
package data_mem_pkg;

  // Line-fill sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } fill_state_t;

  // Default geometry, kept here so the top, the interface and the bench agree.
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DEPTH_WORDS = 1024;
  localparam int DEF_LINE_WORDS  = 16;
  localparam int DEF_FILL_LAT    = 2;

  // Index width for a count of n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Byte-address bits below the line base (word-in-line plus byte offset).
  function automatic int line_off_bits(input int line_words);
    return idx_w(line_words) + 2;
  endfunction

  localparam int DEF_WORD_IDX_W = idx_w(DEF_DEPTH_WORDS);
  localparam int DEF_LINE_IDX_W = idx_w(DEF_LINE_WORDS);

endpackage

// File: rtl/data_mem_burst_if.sv
// Core-side bus of the burst data memory: word load/store plus line-fill stream.
interface data_mem_burst_if
  import data_mem_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS
);
  localparam int LIW = idx_w(LINE_WORDS);

  // word port
  logic              WE;
  logic [ADDR_W-1:0] WA;
  logic [DATA_W-1:0] WD;
  logic [ADDR_W-1:0] RA;
  logic [DATA_W-1:0] RD;

  // line-fill port
  logic              LineReq;
  logic [ADDR_W-1:0] LineA;
  logic              LineReqReady;
  logic              LineDataValid;
  logic              LineDataReady;
  logic [DATA_W-1:0] LineData;
  logic [LIW-1:0]    LineIdx;
  logic              LineLast;

  modport slave (
    input  WE, WA, WD, RA, LineReq, LineA, LineDataReady,
    output RD, LineReqReady, LineDataValid, LineData, LineIdx, LineLast
  );

  modport master (
    output WE, WA, WD, RA, LineReq, LineA, LineDataReady,
    input  RD, LineReqReady, LineDataValid, LineData, LineIdx, LineLast
  );

endinterface

// File: rtl/data_mem_burst_line_fill_fsm.sv
// Line-fill sequencer: accepts a request, waits the fill latency, then walks
// the line one beat per handshake and tells the top which word to capture.
module line_fill_fsm
  import data_mem_pkg::*;
#(
  parameter  int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter  int LINE_WORDS  = DEF_LINE_WORDS,
  parameter  int FILL_LAT    = DEF_FILL_LAT,
  parameter  int CWF         = 0,
  localparam int WIW         = idx_w(DEPTH_WORDS),
  localparam int LIW         = idx_w(LINE_WORDS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           line_req,
  input  logic [WIW-1:0] line_word,   // word index of the critical word
  input  logic           data_ready,
  output logic           req_ready,
  output logic           data_valid,
  output logic           load,        // capture mem[rd_idx] into the beat register
  output logic [WIW-1:0] rd_idx,
  output logic [LIW-1:0] line_idx,
  output logic           line_last
);

  localparam int LCW = idx_w(FILL_LAT + 1);

  fill_state_t    state, state_n;
  logic [LCW-1:0] lat_cnt;
  logic [LIW-1:0] beat_cnt;     // k of the beat currently presented
  logic [LIW-1:0] load_k;       // k of the beat being loaded this edge
  logic [LIW-1:0] start_q, start_in, start_cur;
  logic [WIW-1:0] base_q, base_in, base_cur;
  logic [LIW-1:0] fill_pos;
  logic           accept;

  // Line base clears the word-in-line bits; start index depends on wrap mode.
  assign base_in  = line_word & ~WIW'(LINE_WORDS - 1);
  assign start_in = (CWF != 0) ? line_word[LIW-1:0] : '0;
  assign accept   = (state == IDLE) && line_req;

  // With zero fill latency beat 0 loads on the accept edge, before the
  // latched base/start exist, so take them straight from the request.
  assign base_cur  = (state == IDLE) ? base_in  : base_q;
  assign start_cur = (state == IDLE) ? start_in : start_q;
  assign fill_pos  = start_cur + load_k;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and the beat-load decision.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    load_k  = '0;
    unique case (state)
      IDLE: begin
        if (line_req) begin
          if (FILL_LAT == 0) begin
            state_n = BURST;
            load    = 1'b1;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (int'(lat_cnt) == FILL_LAT - 1) begin
          state_n = BURST;
          load    = 1'b1;
        end
      end
      BURST: begin
        if (data_ready) begin
          if (line_last) begin
            state_n = IDLE;
          end else begin
            load   = 1'b1;
            load_k = beat_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Handshake outputs and the memory read index for the beat being loaded.
  always_comb begin
    req_ready  = (state == IDLE);
    data_valid = (state == BURST);
    rd_idx     = base_cur | WIW'(fill_pos);
  end

  // Request latch, latency counter and per-beat index/last registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt   <= '0;
      beat_cnt  <= '0;
      start_q   <= '0;
      base_q    <= '0;
      line_idx  <= '0;
      line_last <= 1'b0;
    end else begin
      if (accept) begin
        base_q   <= base_in;
        start_q  <= start_in;
        beat_cnt <= '0;
        lat_cnt  <= '0;
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt + 1'b1;
      end
      if (load) begin
        beat_cnt  <= load_k;
        line_idx  <= fill_pos;
        line_last <= (load_k == LIW'(LINE_WORDS - 1));
      end
    end
  end

endmodule

// File: rtl/data_mem_burst.sv
// Data memory with a combinational word load port, a word store port and a
// registered line-fill stream under valid/ready.
module data_mem_burst
  import data_mem_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int LINE_WORDS  = DEF_LINE_WORDS,
  parameter int FILL_LAT    = DEF_FILL_LAT,
  parameter int CWF         = 0
) (
  input logic             CLK,
  input logic             Reset,
  data_mem_burst_if.slave bus
);

  localparam int WIW = idx_w(DEPTH_WORDS);

  // Geometry sanity, caught at elaboration.
  if (LINE_WORDS < 2 || (1 << $clog2(LINE_WORDS)) != LINE_WORDS)
    $error("LINE_WORDS must be a power of two >= 2");
  if ((1 << $clog2(DEPTH_WORDS)) != DEPTH_WORDS || DEPTH_WORDS < LINE_WORDS)
    $error("DEPTH_WORDS must be a power of two >= LINE_WORDS");
  if (ADDR_W < WIW + 2)
    $error("ADDR_W too narrow for DEPTH_WORDS");

  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [WIW-1:0]    wa_idx, ra_idx, fill_idx;
  logic              load;

  // Upper address bits are dropped so accesses wrap modulo the depth.
  assign wa_idx = bus.WA[WIW+1:2];
  assign ra_idx = bus.RA[WIW+1:2];

  line_fill_fsm #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .LINE_WORDS  (LINE_WORDS),
    .FILL_LAT    (FILL_LAT),
    .CWF         (CWF)
  ) u_fsm (
    .clk        (CLK),
    .rst        (Reset),
    .line_req   (bus.LineReq),
    .line_word  (bus.LineA[WIW+1:2]),
    .data_ready (bus.LineDataReady),
    .req_ready  (bus.LineReqReady),
    .data_valid (bus.LineDataValid),
    .load       (load),
    .rd_idx     (fill_idx),
    .line_idx   (bus.LineIdx),
    .line_last  (bus.LineLast)
  );

  // Word store; contents survive reset.
  always_ff @(posedge CLK) begin
    if (bus.WE) mem[wa_idx] <= bus.WD;
  end

  assign bus.RD = mem[ra_idx];

  // Beat register: samples the array on the load edge, so a same-edge
  // write is not seen and later writes never disturb a held beat.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)     bus.LineData <= '0;
    else if (load) bus.LineData <= mem[fill_idx];
  end

endmodule

// File: tb/tb_data_mem_burst.sv
// Scoreboard bench: two instances (CWF=0/FILL_LAT=2 and CWF=1/FILL_LAT=0)
// share the word port; each line port has its own expected-beat queue.
module tb_data_mem_burst;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        we, req0, req1, rdy0, rdy1;
  logic [31:0] wa, wd, ra, la;

  data_mem_burst_if #(.DATA_W(32), .ADDR_W(32), .LINE_WORDS(16)) b0 ();
  data_mem_burst_if #(.DATA_W(32), .ADDR_W(32), .LINE_WORDS(16)) b1 ();

  assign b0.WE = we;  assign b0.WA = wa;  assign b0.WD = wd;  assign b0.RA = ra;
  assign b1.WE = we;  assign b1.WA = wa;  assign b1.WD = wd;  assign b1.RA = ra;
  assign b0.LineReq = req0;  assign b0.LineA = la;  assign b0.LineDataReady = rdy0;
  assign b1.LineReq = req1;  assign b1.LineA = la;  assign b1.LineDataReady = rdy1;

  data_mem_burst #(.FILL_LAT(2), .CWF(0)) dut0 (.CLK(clk), .Reset(rst), .bus(b0));
  data_mem_burst #(.FILL_LAT(0), .CWF(1)) dut1 (.CLK(clk), .Reset(rst), .bus(b1));

  int errors = 0;
  int checks = 0;

  logic [31:0] model [1024];
  beat_t q0[$];
  beat_t q1[$];

  bit          stl [2];
  logic [31:0] hd  [2];
  logic [3:0]  hi  [2];
  logic        hl  [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a line is 16 words from the 64-byte-aligned base, starting
  // at the critical word (wrap mode) or at word 0.
  task automatic push(input int d, input logic [31:0] a);
    logic [9:0] base;
    logic [3:0] s;
    beat_t e;
    base = {a[11:6], 4'b0000};
    s    = (d == 1) ? a[5:2] : 4'd0;
    for (int k = 0; k < 16; k++) begin
      e.idx  = 4'(int'(s) + k);
      e.data = model[base + 10'(e.idx)];
      e.last = (k == 15);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic mon(input int d, input logic v, input logic r, input logic [31:0] data,
                     input logic [3:0] idx, input logic last);
    beat_t e;
    int    sz;
    if (stl[d]) begin
      chk($sformatf("hold_valid%0d", d), v, 1'b1);
      chk($sformatf("hold_data%0d", d), data, hd[d]);
      chk($sformatf("hold_idx%0d", d), idx, hi[d]);
      chk($sformatf("hold_last%0d", d), last, hl[d]);
    end
    if (v && r) begin
      sz = (d == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_beat%0d: got beat idx %0d data %h, expected none", d, idx, data);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("beat_data%0d", d), data, e.data);
        chk($sformatf("beat_idx%0d", d), idx, e.idx);
        chk($sformatf("beat_last%0d", d), last, e.last);
      end
    end
    stl[d] = v && !r;
    hd[d]  = data;
    hi[d]  = idx;
    hl[d]  = last;
  endtask

  // Monitor: consumes a beat whenever a handshake is about to happen.
  always @(negedge clk) begin
    if (rst) begin
      stl[0] = 1'b0;
      stl[1] = 1'b0;
    end else begin
      mon(0, b0.LineDataValid, rdy0, b0.LineData, b0.LineIdx, b0.LineLast);
      mon(1, b1.LineDataValid, rdy1, b1.LineData, b1.LineIdx, b1.LineLast);
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    @(posedge clk); #1;
    we = 1'b0;
    model[a[11:2]] = d;
  endtask

  task automatic rd_check();
    ra = $urandom;
    #1;
    chk("rd0", b0.RD, model[ra[11:2]]);
    chk("rd1", b1.RD, model[ra[11:2]]);
  endtask

  task automatic req(input bit d0, input bit d1, input logic [31:0] a);
    req0 = d0; req1 = d1; la = a;
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic issue(input bit d0, input bit d1, input logic [31:0] a);
    if (d0) push(0, a);
    if (d1) push(1, a);
    req(d0, d1, a);
  endtask

  task automatic wait_idle(input bit rnd);
    int n = 0;
    while (!(b0.LineReqReady && b1.LineReqReady && q0.size() == 0 && q1.size() == 0)
           && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (rnd) begin
        rdy0 = ($urandom_range(0, 3) != 0);
        rdy1 = ($urandom_range(0, 3) != 0);
        rd_check();
      end
    end
    chk("idle_within_bound", 32'(n < 400), 1);
    rdy0 = 1'b1;
    rdy1 = 1'b1;
  endtask

  task automatic wait_beat0(input logic [3:0] idx);
    int n = 0;
    while (!(b0.LineDataValid && b0.LineIdx == idx) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("beat_within_bound", 32'(n < 100), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int    v0, v1, r0, r1, extra;
    beat_t e;
    we = 0; wa = 0; wd = 0; ra = 0; la = 0;
    req0 = 0; req1 = 0; rdy0 = 1; rdy1 = 1;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", b0.LineReqReady, 1);   chk("rst_ready1", b1.LineReqReady, 1);
    chk("rst_valid0", b0.LineDataValid, 0);  chk("rst_valid1", b1.LineDataValid, 0);
    chk("rst_data0", b0.LineData, 0);        chk("rst_data1", b1.LineData, 0);
    chk("rst_idx0", b0.LineIdx, 0);          chk("rst_idx1", b1.LineIdx, 0);
    chk("rst_last0", b0.LineLast, 0);        chk("rst_last1", b1.LineLast, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // mem[i] = i
    for (int i = 0; i < 1024; i++) wr(32'(i * 4), 32'(i));

    // word port: same-cycle read sees the old value, next cycle the new one
    ra = 32'h44; we = 1'b1; wa = 32'h44; wd = 32'hDEADBEEF;
    #1;
    chk("rd_during_write", b0.RD, 32'h11);
    @(posedge clk); #1;
    we = 1'b0;
    model[17] = 32'hDEADBEEF;
    chk("rd_after_write0", b0.RD, 32'hDEADBEEF);
    chk("rd_after_write1", b1.RD, 32'hDEADBEEF);
    wr(32'h44, 32'h11);

    // line at 0x48 on both; latency to first beat and back to ready
    issue(1, 1, 32'h48);
    v0 = -1; v1 = -1; r0 = -1; r1 = -1;
    for (int n = 0; n < 40; n++) begin
      if (v0 < 0 && b0.LineDataValid) v0 = n;
      if (v1 < 0 && b1.LineDataValid) v1 = n;
      if (r0 < 0 && b0.LineReqReady)  r0 = n;
      if (r1 < 0 && b1.LineReqReady)  r1 = n;
      @(posedge clk); #1;
    end
    chk("first_valid0", v0, 2);
    chk("first_valid1", v1, 0);
    chk("ready_back0", r0, 18);
    chk("ready_back1", r1, 16);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    // backpressure at beat 4; writes to word 4 and word 9 during the stall
    push(0, 32'h0);
    e = q0[9]; e.data = 32'h55; q0[9] = e;
    req(1, 0, 32'h0);
    wait_beat0(4'd4);
    rdy0 = 1'b0;
    wr(32'h10, 32'h55);
    wr(32'h24, 32'h55);
    @(posedge clk); #1;
    chk("stall_idx", b0.LineIdx, 4);
    chk("stall_data", b0.LineData, 4);
    rdy0 = 1'b1;
    wait_idle(0);
    wr(32'h10, 32'h4);
    wr(32'h24, 32'h9);

    // request pulsed mid-burst is ignored
    issue(1, 0, 32'h100);
    wait_beat0(4'd3);
    req0 = 1'b1; la = 32'h200;
    @(posedge clk); #1;
    req0 = 1'b0;
    wait_idle(0);
    extra = 0;
    for (int n = 0; n < 30; n++) begin
      if (b0.LineDataValid) extra++;
      @(posedge clk); #1;
    end
    chk("no_second_line", extra, 0);

    // reset mid-burst at beat 5, then a fresh line at 0x80
    issue(1, 0, 32'h0);
    wait_beat0(4'd5);
    rst = 1'b1;
    q0.delete();
    @(negedge clk);
    chk("mid_rst_valid", b0.LineDataValid, 0);
    chk("mid_rst_ready", b0.LineReqReady, 1);
    chk("mid_rst_idx", b0.LineIdx, 0);
    chk("mid_rst_data", b0.LineData, 0);
    chk("mid_rst_last", b0.LineLast, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    issue(1, 0, 32'h80);
    wait_idle(0);

    // randomized lines with random backpressure and random loads
    for (int it = 0; it < 25; it++) begin
      for (int w = 0; w < 3; w++) begin
        wr($urandom, $urandom);
        rd_check();
      end
      issue(1, 1, $urandom);
      wait_idle(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_burst.md
# data_mem_burst

Parametrised data memory for the superscalar MIPS top level, the successor to the fixed 16-word parallel cache-read data memory. It keeps the single-word load/store port used by the core. The 16 parallel cache read ports are replaced by a line-fill port that streams one cache line as a sequence of beats under a valid/ready handshake. Line size, depth, fill latency and wrap mode are parameters. It sits between the `mips` core/data cache and the top-level wiring.

## Interface
Parameters:
- `DATA_W`, default 32: word width in bits.
- `ADDR_W`, default 32: byte-address width.
- `DEPTH_WORDS`, default 1024: memory depth; power of two.
- `LINE_WORDS`, default 16: words per line; power of two, ≥2.
- `FILL_LAT`, default 2: idle cycles between request acceptance and the first beat; 0 is allowed.
- `CWF`, default 0: wrap mode. 1 = critical-word-first (start at the requested word, wrap within the line). 0 = start at word 0.

Ports:
- `CLK` in 1: clock, rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `WE` in 1: word write enable.
- `WA` in ADDR_W: write byte address.
- `WD` in DATA_W: write data.
- `RA` in ADDR_W: load byte address.
- `RD` out DATA_W: load data, combinational.
- `LineReq` in 1: line-fill request.
- `LineA` in ADDR_W: byte address of the critical word.
- `LineReqReady` out 1: block can accept a request.
- `LineDataValid` out 1: a beat is presented.
- `LineDataReady` in 1: consumer accepts the beat.
- `LineData` out DATA_W: beat data, registered.
- `LineIdx` out log2(LINE_WORDS): word index of the beat within the line.
- `LineLast` out 1: this is the final beat of the line.

## Operation
- Word index = `A[log2(DEPTH_WORDS)+1:2]`. Upper bits are ignored, so addresses wrap modulo DEPTH_WORDS. Bits [1:0] are ignored.
- Write: on a rising edge with `WE`=1, `mem[WA]` ← `WD`. `RD` = `mem[RA]` combinationally; a same-cycle write becomes visible after the edge.
- Memory contents are not affected by `Reset`.
- FSM states: IDLE, WAIT, BURST. `LineReqReady` = (state == IDLE).
  - IDLE → WAIT on an edge with `LineReq`=1. Latch line base (`LineA` with the low log2(LINE_WORDS)+2 bits cleared) and start index s (CWF=1: `LineA` word-in-line; CWF=0: 0). Clear the beat counter.
  - If FILL_LAT=0, go straight from IDLE to BURST instead, loading beat 0 on the same edge.
  - WAIT counts FILL_LAT edges, then → BURST, loading beat 0.
  - Loading beat k: `LineIdx` ← (s+k) mod LINE_WORDS; `LineData` ← `mem[base + that index]` sampled at that edge (pre-write value if `WE` hits the same word); `LineLast` ← (k == LINE_WORDS−1).
  - BURST: `LineDataValid`=1. On an edge with `LineDataReady`=1, load beat k+1, or → IDLE if `LineLast`. With `LineDataReady`=0, all `Line*` outputs hold, even if memory is written.
- `LineReq` is ignored outside IDLE. A new request is accepted no earlier than the cycle after the last beat handshake.
- Reset, at any time including mid-burst: state IDLE, counters 0. Outputs: `LineReqReady`=1, `LineDataValid`=0, `LineData`=0, `LineIdx`=0, `LineLast`=0. The aborted line is not resumed.

## Timing
- `RD`: 0-cycle latency.
- Request accepted at edge E0. First beat visible after edge E0+FILL_LAT (FILL_LAT=0: after E0).
- With no stall, a line takes LINE_WORDS consecutive valid cycles.
- A full line occupies FILL_LAT+LINE_WORDS+1 cycles from acceptance to the next `LineReqReady`, counting the IDLE cycle.
- Each stall cycle adds exactly one cycle.
- A write landing before a beat's load edge is reflected in that beat. A write on or after the load edge is not.

## Structure
- Package `data_mem_pkg`: FSM state enum (IDLE/WAIT/BURST), and index-width/line-base helper constants derived from LINE_WORDS and DEPTH_WORDS.
- One sub-module, `line_fill_fsm`: state, latency counter, beat counter and index generation; it issues a memory read index. The top holds the memory array, write port, load port and `LineData` register.

## Test plan
- Reset asserted mid-burst (beat 5, CWF=0) → next cycle `LineDataValid`=0, `LineReqReady`=1, `LineIdx`=0. A new request for 0x80 then streams indices 0..15 from base 0x80.
- Write 0xDEADBEEF to 0x44, read `RA`=0x44 in the next cycle → `RD`=0xDEADBEEF. With `RA`=0x44 during the write cycle → old value.
- CWF=0, FILL_LAT=2, mem[i]=i, `LineA`=0x48, ready held high → valid rises 2 cycles after acceptance. Beats carry `LineIdx` 0..15 and data 16..31. `LineLast` only on idx 15. `LineReqReady` returns one cycle after the last beat.
- CWF=1, FILL_LAT=0, same `LineA`=0x48 → idx sequence 2,3,…,15,0,1, data 18..31,16,17. `LineLast` on idx 1.
- Backpressure: drop `LineDataReady` for 3 cycles at beat 4 → `LineData`/`LineIdx` held. Then write 0x55 to word 4 while it is stalled → beat still delivers the old value. Write to word 9 → beat 9 delivers 0x55.
- `LineReq` pulsed during BURST → ignored; exactly 16 beats are delivered and no second line follows.
